tt_um_ejemplo_sumador_1bit: RTL and testbench

- Tiny Tapeout user tile built around a 1-bit full adder.
- The combinational full-adder result is driven straight to dedicated outputs.
- A clocked serial-adder datapath wraps the same adder: carry register, 8-bit sum shift register and step counter. Multi-bit operands can be added LSB-first, one bit per step.
- Sits at the top level of the tile and connects directly to the TT pad ring signals.

---
 rtl/tt_um_ejemplo_sumador_1bit.sv | 88 ++++++++
 tb/tb_tt_um_ejemplo_sumador_1bit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_ejemplo_sumador_1bit.sv
// Tiny Tapeout tile: a 1-bit full adder exposed combinationally, wrapped by a
// serial-adder datapath (carry register, 8-bit sum shift register, step counter).

module tt_um_ejemplo_sumador_1bit_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module tt_um_ejemplo_sumador_1bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic       a;
    logic       b;
    logic       cin_ext;
    logic       step;
    logic       use_carry;
    logic       clr;

    logic       cin_eff;
    logic       sum;
    logic       cout;

    logic       carry_q;
    logic [7:0] sum_sr_q;
    logic [3:0] cnt_q;

    logic       unused_bits;

    assign a         = ui_in[0];
    assign b         = ui_in[1];
    assign cin_ext   = ui_in[2];
    assign step      = ui_in[3];
    assign use_carry = ui_in[4];
    assign clr       = ui_in[5];

    assign unused_bits = &{1'b0, ui_in[7:6], uio_in};

    // The carry-in comes from the register while chaining bits, otherwise from the pin.
    assign cin_eff = use_carry ? carry_q : cin_ext;

    tt_um_ejemplo_sumador_1bit_fa u_fa (
        .a    (a),
        .b    (b),
        .cin  (cin_eff),
        .sum  (sum),
        .cout (cout)
    );

    // rst_n is active-high here despite its name: 1 clears, 0 runs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            carry_q  <= 1'b0;
            sum_sr_q <= 8'h00;
            cnt_q    <= 4'h0;
        end else if (ena) begin
            if (clr) begin
                carry_q  <= 1'b0;
                sum_sr_q <= 8'h00;
                cnt_q    <= 4'h0;
            end else if (step) begin
                carry_q  <= cout;
                sum_sr_q <= {sum, sum_sr_q[7:1]};
                cnt_q    <= cnt_q + 4'd1;
            end
        end
    end

    assign uo_out  = {1'b0, cnt_q, carry_q, cout, sum};
    assign uio_out = sum_sr_q;
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_ejemplo_sumador_1bit.sv
// Self-checking bench for the serial full-adder tile: truth-table vectors,
// directed serial additions and corner cases, then randomized traffic against an arithmetic model.

module tb_tt_um_ejemplo_sumador_1bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state kept as plain integers.
    int m_carry;
    int m_sum_reg;
    int m_count;

    typedef struct {
        logic a;
        logic b;
        logic cin;
        logic exp_sum;
        logic exp_cout;
    } comb_vec_t;

    comb_vec_t comb_table[8];

    tt_um_ejemplo_sumador_1bit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Ignored input bits are randomized to show they have no effect.
    task automatic applyStimulus(input logic a, input logic b, input logic cin,
                                 input logic step, input logic use_carry, input logic clr);
        logic [1:0] junk;
        junk   = 2'($urandom_range(0, 3));
        ui_in  = {junk, clr, use_carry, step, cin, b, a};
        uio_in = 8'($urandom_range(0, 255));
    endtask

    function automatic logic [1:0] modelComb();
        int total;
        int cin_val;
        cin_val = ui_in[4] ? m_carry : int'(ui_in[2]);
        total   = int'(ui_in[0]) + int'(ui_in[1]) + cin_val;
        return {logic'(total / 2), logic'(total % 2)};
    endfunction

    function automatic logic [7:0] modelUo();
        logic [1:0] cs;
        logic [3:0] cnt4;
        cs   = modelComb();
        cnt4 = 4'(m_count);
        return {1'b0, cnt4, logic'(m_carry), cs};
    endfunction

    task automatic modelClear();
        m_carry   = 0;
        m_sum_reg = 0;
        m_count   = 0;
    endtask

    // One rising edge; the model advances using the inputs present at that edge.
    task automatic tick();
        int total;
        int cin_val;
        cin_val = ui_in[4] ? m_carry : int'(ui_in[2]);
        total   = int'(ui_in[0]) + int'(ui_in[1]) + cin_val;
        @(posedge clk);
        if (rst_n) begin
            modelClear();
        end else if (ena) begin
            if (ui_in[5]) begin
                modelClear();
            end else if (ui_in[3]) begin
                m_sum_reg = (m_sum_reg >> 1) + ((total % 2) * 128);
                m_carry   = total / 2;
                m_count   = (m_count + 1) % 16;
            end
        end
        #1;
    endtask

    task automatic checkAgainstModel(input string name);
        checkOutput({name, ".uo_out"}, 32'(uo_out), 32'(modelUo()));
        checkOutput({name, ".uio_out"}, 32'(uio_out), 32'(m_sum_reg));
        checkOutput({name, ".uio_oe"}, 32'(uio_oe), 32'hFF);
    endtask

    task automatic serialAdd(input logic [7:0] x, input logic [7:0] y);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(x[i], y[i], 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
    endtask

    task automatic stepN(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            tick();
        end
    endtask

    initial begin
        comb_table[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        comb_table[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        comb_table[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        comb_table[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        comb_table[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        comb_table[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        comb_table[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        comb_table[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b1;
        ena   = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        modelClear();

        // Combinational truth table, no clock edge needed.
        #2;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(comb_table[i].a, comb_table[i].b, comb_table[i].cin, 1'b0, 1'b0, 1'b0);
            #1;
            checkOutput($sformatf("comb[%0d]", i), 32'(uo_out[1:0]),
                        32'({comb_table[i].exp_cout, comb_table[i].exp_sum}));
        end

        // Reset held for two clocks.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset.uio_out", 32'(uio_out), 32'h00);
        checkOutput("reset.uo_hi", 32'(uo_out[7:2]), 32'h00);
        checkOutput("reset.uio_oe", 32'(uio_oe), 32'hFF);
        checkOutput("reset.comb", 32'(uo_out[1:0]), 32'b10);
        rst_n = 1'b0;

        // 0x5A + 0x3C = 0x96, no carry out.
        serialAdd(8'h5A, 8'h3C);
        checkOutput("add5A3C.sum", 32'(uio_out), 32'h96);
        checkOutput("add5A3C.carry", 32'(uo_out[2]), 32'h0);
        checkOutput("add5A3C.cnt", 32'(uo_out[6:3]), 32'h8);
        checkAgainstModel("add5A3C");

        // 0xFF + 0x01 = 0x100.
        serialAdd(8'hFF, 8'h01);
        checkOutput("addFF01.sum", 32'(uio_out), 32'h00);
        checkOutput("addFF01.carry", 32'(uo_out[2]), 32'h1);
        checkOutput("addFF01.cnt", 32'(uo_out[6:3]), 32'h8);

        // External carry-in injected on the first bit: 0x0F + 0x10 + 1 = 0x20.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 1; i < 8; i++) begin
            applyStimulus(logic'(i < 4), logic'(i == 4), 1'b0, 1'b1, 1'b1, 1'b0);
            tick();
        end
        checkOutput("addCin.sum", 32'(uio_out), 32'h20);
        checkOutput("addCin.carry", 32'(uo_out[2]), 32'h0);

        // clr wins over step.
        stepN(3);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("clrstep.regs", 32'({uo_out[6:2], uio_out}), 32'h0);

        // ena=0 freezes the registers even with step asserted.
        stepN(5);
        checkAgainstModel("preHold");
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        checkOutput("hold.uio_out", 32'(uio_out), 32'(m_sum_reg));
        checkOutput("hold.cnt", 32'(uo_out[6:3]), 32'h5);
        checkAgainstModel("hold");
        ena = 1'b1;

        // Reset mid-sequence.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        stepN(4);
        checkOutput("mid.cnt", 32'(uo_out[6:3]), 32'h4);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("midrst.regs", 32'({uo_out[6:2], uio_out}), 32'h0);
        checkOutput("midrst.comb", 32'(uo_out[1:0]), 32'b10);
        checkOutput("midrst.uo7", 32'(uo_out[7]), 32'h0);
        rst_n = 1'b0;

        // Counter wrap.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        stepN(16);
        checkOutput("wrap16.cnt", 32'(uo_out[6:3]), 32'h0);
        stepN(1);
        checkOutput("wrap17.cnt", 32'(uo_out[6:3]), 32'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            rst_n = logic'($urandom_range(0, 19) == 0);
            ena   = logic'($urandom_range(0, 4) != 0);
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), logic'($urandom_range(0, 9) == 0));
            #1;
            checkOutput("rand.comb", 32'(uo_out[1:0]), 32'(modelComb()));
            tick();
            checkAgainstModel("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
